// File: rtl/set_button_conditioner_if.sv
// set_button_conditioner_if: raw button pins in, conditioned level/pulse/hold outputs back
interface set_button_conditioner_if #(parameter int N_BTN = 5);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_held;
  modport master(output btn_raw, input btn_level, btn_press, btn_release, btn_held);
  modport slave(input btn_raw, output btn_level, btn_press, btn_release, btn_held);
endinterface

// File: rtl/set_button_conditioner.sv
// set_button_conditioner: per-channel sync, debounce, press/release pulses and hold auto-repeat
module set_button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input logic clk,
  input logic reset,
  set_button_conditioner_if.slave btn
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic REL = (ACTIVE_LOW != 0);
  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_t;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic r_sync1, r_sync2, r_level, r_level_d, r_press, r_release, r_held;
    logic [DW-1:0] r_deb_cnt;
    logic [RW-1:0] r_rep_cnt;
    state_t r_state;
    logic w_s, w_lvl_nxt, w_tc;
    assign w_s = r_sync2 ^ REL;
    assign w_lvl_nxt = (w_s != r_level && r_deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) ? w_s : r_level;
    assign w_tc = r_level && ((r_state == WAIT_HOLD && r_rep_cnt == RW'(HOLD_CYCLES - 1)) ||
                              (r_state == REPEAT && r_rep_cnt == RW'(REPEAT_CYCLES - 1)));
    // held and repeat pulses look at the next level so they die on the same edge the level falls
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_sync1   <= REL;
        r_sync2   <= REL;
        r_deb_cnt <= '0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_held    <= 1'b0;
        r_state   <= IDLE;
        r_rep_cnt <= '0;
      end else begin
        r_sync1   <= btn.btn_raw[i];
        r_sync2   <= r_sync1;
        r_deb_cnt <= (w_s == r_level || w_lvl_nxt != r_level) ? '0 : r_deb_cnt + 1'b1;
        r_level   <= w_lvl_nxt;
        r_level_d <= r_level;
        r_press   <= (r_level & ~r_level_d) | (w_tc & w_lvl_nxt);
        r_release <= ~r_level & r_level_d;
        r_held    <= w_lvl_nxt & (w_tc | ((r_state == REPEAT) & r_level));
        if (REPEAT_EN == 0 || !r_level) begin
          r_state   <= IDLE;
          r_rep_cnt <= '0;
        end else if (r_state == IDLE) begin
          r_state   <= WAIT_HOLD;
          r_rep_cnt <= '0;
        end else if (w_tc) begin
          r_state   <= REPEAT;
          r_rep_cnt <= '0;
        end else
          r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    assign btn.btn_level[i]   = r_level;
    assign btn.btn_press[i]   = r_press;
    assign btn.btn_release[i] = r_release;
    assign btn.btn_held[i]    = r_held;
  end
endmodule

// File: tb/tb_set_button_conditioner.sv
// tb_set_button_conditioner: directed and random stimulus against a sliding-window/age reference model
module tb_set_button_conditioner;
  localparam int N = 5;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  set_button_conditioner_if #(.N_BTN(N)) bus ();
  set_button_conditioner #(
    .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(bus.slave)
  );
  always #5 clk = ~clk;
  logic [D+1:0] win [N];
  logic l0 [N], l1 [N], l2 [N];
  int age [N];
  logic [N-1:0] e_level, e_press, e_release, e_held;
  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      win[c] = '0;
      l0[c] = 1'b0;
      l1[c] = 1'b0;
      l2[c] = 1'b0;
      age[c] = -1;
    end
    e_level = '0;
    e_press = '0;
    e_release = '0;
    e_held = '0;
  endfunction
  // a level flips once the D samples seen through the 2-stage synchroniser all disagree with it
  function automatic void model_edge(input logic [N-1:0] raw);
    logic [D-1:0] w;
    for (int c = 0; c < N; c++) begin
      win[c] = {win[c][D:0], ~raw[c]};
      w = win[c][D+1:2];
      l2[c] = l1[c];
      l1[c] = l0[c];
      if (l1[c] ? (w == '0) : (&w)) l0[c] = ~l1[c];
      age[c] = !l0[c] ? -1 : (!l1[c] ? 0 : age[c] + 1);
      e_level[c] = l0[c];
      e_press[c] = (l1[c] & ~l2[c]) | (l0[c] && age[c] >= H + 1 && (age[c] - H - 1) % R == 0);
      e_release[c] = ~l1[c] & l2[c];
      e_held[c] = l0[c] && age[c] >= H + 1;
    end
  endfunction
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge(bus.btn_raw);
    @(negedge clk);
    chk("level", bus.btn_level, e_level);
    chk("press", bus.btn_press, e_press);
    chk("release", bus.btn_release, e_release);
    chk("held", bus.btn_held, e_held);
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    bus.btn_raw = 5'b11111;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_level", bus.btn_level, '0);
    chk("reset_press", bus.btn_press, '0);
    run(50);
    bus.btn_raw[0] = 1'b0;
    run(12);
    bus.btn_raw[0] = 1'b1;
    run(10);
    bus.btn_raw[2] = 1'b0;
    run(3);
    bus.btn_raw[2] = 1'b1;
    run(10);
    bus.btn_raw[2] = 1'b0;
    run(4);
    bus.btn_raw[2] = 1'b1;
    run(12);
    bus.btn_raw[1] = 1'b0;
    run(6 + 60);
    bus.btn_raw[1] = 1'b1;
    run(15);
    bus.btn_raw = 5'b00000;
    run(10);
    bus.btn_raw = 5'b11111;
    run(10);
    bus.btn_raw[4] = 1'b0;
    run(6 + 30);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_level", bus.btn_level, '0);
    chk("async_rst_press", bus.btn_press, '0);
    chk("async_rst_release", bus.btn_release, '0);
    chk("async_rst_held", bus.btn_held, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(40);
    bus.btn_raw[4] = 1'b1;
    run(12);
    for (int s = 0; s < 150; s++) begin
      bus.btn_raw = 5'($urandom);
      run(int'($urandom_range(1, 30)));
    end
    bus.btn_raw = 5'b11111;
    run(15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/set_button_conditioner.md
Name: set_button_conditioner

Overview:
- Conditions the five raw SET push-buttons before they reach the SET PIO input port (`in_port[4:0]`).
- Per channel it provides:
  - a 2-FF synchroniser;
  - a consecutive-sample debouncer;
  - a clean level output;
  - one-cycle press/release pulses;
  - optional hold-to-auto-repeat pulses for time/value setting.
- `btn_level` drives the PIO data/IRQ path.
- `btn_press` / `btn_release` are available to hardware consumers.

Parameters:
- N_BTN, 5, number of button channels.
- ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed (board buttons); 0 = active-high.
- DEBOUNCE_CYCLES, 500000, consecutive mismatching synchronised samples needed to accept a change (10 ms @ 50 MHz); legal range ≥1.
- REPEAT_EN, 1, 1 = generate auto-repeat pulses while held.
- HOLD_CYCLES, 25000000, cycles from accepted press to first repeat pulse; legal range ≥1.
- REPEAT_CYCLES, 10000000, cycles between subsequent repeat pulses; legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  N_BTN  raw asynchronous button pins.
- btn_level  output  N_BTN  debounced level, 1 = pressed; connects to PIO `in_port`.
- btn_press  output  N_BTN  1-cycle pulse on accepted press and on each auto-repeat.
- btn_release  output  N_BTN  1-cycle pulse on accepted release.
- btn_held  output  N_BTN  1 while pressed and HOLD_CYCLES has elapsed (repeat phase).

Behaviour:
- Reset (async assert, release synchronous to clk):
  - Synchroniser flops are forced to the "released" value (1 if ACTIVE_LOW, else 0).
  - All counters are set to 0.
  - All outputs are 0.
  - Reset mid-press: outputs drop to 0 immediately. After reset, a still-held button needs a full debounce before `btn_level` rises again; no release pulse is generated by reset.
- Polarity: `s = sync2 XOR ACTIVE_LOW`, so 1 = pressed internally.
- Debounce, per channel, independent:
  - `deb_cnt` counts clocks where `s != btn_level`, and clears to 0 on any cycle where `s == btn_level`.
  - When `s != btn_level` and `deb_cnt == DEBOUNCE_CYCLES-1`, the next edge sets `btn_level <= s` and `deb_cnt <= 0`.
  - Latency: a clean raw transition reaches `btn_level` 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value.
  - A glitch shorter than DEBOUNCE_CYCLES produces no output change.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`; the counter never wraps.
- Pulses:
  - `btn_press` is asserted for exactly the cycle after `btn_level` goes 0→1.
  - `btn_release` is asserted for the cycle after `btn_level` goes 1→0.
  - Press and release pulses are never asserted together on one channel.
- Repeat FSM, per channel; states IDLE, WAIT_HOLD, REPEAT:
  - IDLE: waits for `btn_level` to rise → WAIT_HOLD, `rep_cnt <= 0`.
  - WAIT_HOLD: `rep_cnt` increments each cycle. At `rep_cnt == HOLD_CYCLES-1` → REPEAT, issue one `btn_press` pulse, `rep_cnt <= 0`.
  - REPEAT: `btn_held = 1`. `rep_cnt` increments; at `REPEAT_CYCLES-1`, issue a pulse and reset the count to 0.
  - From any state, `btn_level == 0` → IDLE, `rep_cnt <= 0`, `btn_held = 0`. A release on the same cycle as a repeat terminal count suppresses that repeat pulse.
  - With REPEAT_EN = 0, the FSM stays in IDLE, `btn_held` stays 0, and only the edge press pulse is produced.
- Channels do not interact; simultaneous presses on several channels yield simultaneous independent pulses.
- All outputs are registered; there is no combinational path from `btn_raw` to any output.

Test Plan (bench params: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1):
- Reset, then `btn_raw = 5'b11111` held → all outputs 0 for 50 cycles. Assert `reset` mid-cycle → outputs 0 immediately, without waiting for a clock edge.
- `btn_raw[0]` 1→0 held → `btn_level[0]` rises 6 edges later; `btn_press[0]` is high exactly 1 cycle after that; other channels stay 0.
- `btn_raw[2]` low for 3 cycles then high (glitch) → no change on any output. Low for 4 cycles → `btn_level[2]` = 1.
- Hold `btn_raw[1]` low for 60 cycles after acceptance, then release:
  - `btn_press[1]` pulses at +1, +21, +29, +37, +45, +53 cycles relative to the `btn_level` rise;
  - `btn_held[1]` = 1 from +21;
  - on release, `btn_release[1]` is a single pulse and `btn_held[1]` drops the same cycle `btn_level` falls.
- `btn_raw = 5'b00000` simultaneously → all five `btn_level` bits rise on the same edge, with five simultaneous `btn_press` pulses.
- Press and hold channel 4, pulse `reset` during the repeat phase → outputs 0. After reset, `btn_level[4]` rises 6 edges later, followed by a fresh press pulse and restart of the hold timing.
